// File: rtl/gcd_requester.sv
`default_nettype none
// ============================================================================
// Module   : gcd_requester
// Purpose  : Initiator side of the gcd start/finish handshake. Accepts an
//            operand pair over a valid/ready port, fires a one-cycle start
//            pulse at a gcd responder, waits for its finish strobe and
//            returns the result together with the measured responder latency
//            in cycles. A timeout aborts the wait if the responder hangs.
//            Pairs with a zero operand are answered locally (gcd = a|b)
//            without starting the responder.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_valid/in_ready - upstream operand handshake (in_a, in_b)
//            gcd_start         - one-cycle start pulse to the responder
//            gcd_a/gcd_b       - operands, held stable from ISSUE until HOLD
//            gcd_result        - responder result, sampled with gcd_finish
//            gcd_finish        - responder done strobe (ignored outside WAIT)
//            out_valid/out_ready - downstream result handshake
//            out_gcd           - result (0 on timeout)
//            out_cycles        - start-to-finish latency in cycles
//            out_timeout       - result was aborted by timeout
//            stat_min/stat_max/stat_count - latency statistics, present only
//            when GCD_REQ_STATS_EN is defined
// Options  : GCD_REQ_STATS_EN  - adds latency statistics outputs
// Revision : 1.0 - initial release
// ============================================================================
module gcd_requester #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 10000   // must be < 2**CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic [WIDTH-1:0] gcd_result,
    input  logic             gcd_finish,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles,
`ifdef GCD_REQ_STATS_EN
    output logic [CNT_W-1:0] stat_min,
    output logic [CNT_W-1:0] stat_max,
    output logic [CNT_W-1:0] stat_count,
`endif
    output logic             out_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    state_t             state_q;
    logic               in_ready_q;
    logic               gcd_start_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_gcd_q;
    logic [CNT_W-1:0]   out_cycles_q;
    logic               out_timeout_q;

    // Latency including the current edge: the edge that sampled gcd_start
    // is edge 0, so a finish seen on the first WAIT edge reports 1.
    logic [CNT_W-1:0]   cnt_d;
    assign cnt_d = cnt_q + C_ONE;

`ifdef GCD_REQ_STATS_EN
    logic [CNT_W-1:0]   stat_min_q;
    logic [CNT_W-1:0]   stat_max_q;
    logic [CNT_W-1:0]   stat_count_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            gcd_start_q   <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_gcd_q     <= '0;
            out_cycles_q  <= '0;
            out_timeout_q <= 1'b0;
`ifdef GCD_REQ_STATS_EN
            stat_min_q    <= '1;
            stat_max_q    <= '0;
            stat_count_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        in_ready_q <= 1'b0;
                        if ((in_a == '0) || (in_b == '0)) begin
                            // gcd(x,0) = x, so the responder is bypassed.
                            out_gcd_q     <= in_a | in_b;
                            out_cycles_q  <= '0;
                            out_timeout_q <= 1'b0;
                            out_valid_q   <= 1'b1;
                            state_q       <= S_HOLD;
                        end else begin
                            gcd_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    gcd_start_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= S_WAIT;
                end

                S_WAIT: begin
                    // Finish is tested first so it wins over a coincident timeout.
                    if (gcd_finish) begin
                        out_gcd_q     <= gcd_result;
                        out_cycles_q  <= cnt_d;
                        out_timeout_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= S_HOLD;
`ifdef GCD_REQ_STATS_EN
                        if (cnt_d < stat_min_q) begin
                            stat_min_q <= cnt_d;
                        end
                        if (cnt_d > stat_max_q) begin
                            stat_max_q <= cnt_d;
                        end
                        if (stat_count_q != '1) begin
                            stat_count_q <= stat_count_q + C_ONE;
                        end
`endif
                    end else if (cnt_d == C_TIMEOUT) begin
                        out_gcd_q     <= '0;
                        out_cycles_q  <= C_TIMEOUT;
                        out_timeout_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        state_q       <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_HOLD: begin
                    // No accept on the handshake edge; IDLE takes the next
                    // pair one cycle later at the earliest.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    gcd_start_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign gcd_start   = gcd_start_q;
    assign gcd_a       = a_q;
    assign gcd_b       = b_q;
    assign out_valid   = out_valid_q;
    assign out_gcd     = out_gcd_q;
    assign out_cycles  = out_cycles_q;
    assign out_timeout = out_timeout_q;

`ifdef GCD_REQ_STATS_EN
    assign stat_min   = stat_min_q;
    assign stat_max   = stat_max_q;
    assign stat_count = stat_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_requester
// Purpose  : Self-checking bench for gcd_requester with a behavioural
//            responder of programmable latency and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_requester;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic [WIDTH-1:0] gcd_result;
    logic             gcd_finish;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_gcd;
    logic [CNT_W-1:0] out_cycles;
    logic             out_timeout;
`ifdef GCD_REQ_STATS_EN
    logic [CNT_W-1:0] stat_min;
    logic [CNT_W-1:0] stat_max;
    logic [CNT_W-1:0] stat_count;
`endif

    gcd_requester #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .gcd_start   (gcd_start),
        .gcd_a       (gcd_a),
        .gcd_b       (gcd_b),
        .gcd_result  (gcd_result),
        .gcd_finish  (gcd_finish),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gcd     (out_gcd),
        .out_cycles  (out_cycles),
`ifdef GCD_REQ_STATS_EN
        .stat_min    (stat_min),
        .stat_max    (stat_max),
        .stat_count  (stat_count),
`endif
        .out_timeout (out_timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int x = int'(a);
        int y = int'(b);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return WIDTH'(x);
    endfunction

    // Behavioural responder: finish is sampled on the resp_lat-th edge after
    // the edge that sampled gcd_start. resp_lat = 0 means never finish.
    int               resp_lat    = 0;
    int               rem         = -1;
    logic             resp_finish = 1'b0;
    logic [WIDTH-1:0] resp_res    = '0;
    logic             spur_finish = 1'b0;

    assign gcd_finish = resp_finish | spur_finish;
    assign gcd_result = resp_res;

    always @(negedge clk) begin
        resp_finish = 1'b0;
        if (gcd_start === 1'b1) begin
            rem      = resp_lat;
            resp_res = ref_gcd(gcd_a, gcd_b);
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                resp_finish = 1'b1;
                rem         = -1;
            end
        end
    end

    // Start-pulse monitor.
    int               start_cycles = 0;
    logic [WIDTH-1:0] start_a = '0;
    logic [WIDTH-1:0] start_b = '0;

    always @(negedge clk) begin
        if (gcd_start === 1'b1) begin
            start_cycles++;
            start_a = gcd_a;
            start_b = gcd_b;
        end
    end

    typedef struct {
        logic [WIDTH-1:0] g;
        logic [CNT_W-1:0] c;
        logic             t;
    } exp_t;

    exp_t sb[$];

    // Called and returns on a negedge; returns on the negedge after the
    // accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int lat, input bit expect_out);
        int   n = 0;
        exp_t e;
        resp_lat = lat;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        if (expect_out) begin
            if (a == '0 || b == '0) begin
                e = '{g: a | b, c: '0, t: 1'b0};
            end else if (lat == 0 || lat > TIMEOUT) begin
                e = '{g: '0, c: CNT_W'(TIMEOUT), t: 1'b1};
            end else begin
                e = '{g: ref_gcd(a, b), c: CNT_W'(lat), t: 1'b0};
            end
            sb.push_back(e);
        end
    endtask

    task automatic recv(input int hold, input bit spur);
        int   n = 0;
        exp_t e = '{g: '0, c: '0, t: 1'b0};
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 32'(out_valid), 1);
        check("sb_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) e = sb.pop_front();
        check("out_gcd", 32'(out_gcd), 32'(e.g));
        check("out_cycles", 32'(out_cycles), 32'(e.c));
        check("out_timeout", 32'(out_timeout), 32'(e.t));
        for (int i = 0; i < hold; i++) begin
            spur_finish = spur && (i % 3 == 1);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 1);
            check("hold_gcd", 32'(out_gcd), 32'(e.g));
            check("hold_cycles", 32'(out_cycles), 32'(e.c));
            check("hold_timeout", 32'(out_timeout), 32'(e.t));
            check("hold_in_ready", 32'(in_ready), 0);
        end
        spur_finish = 1'b0;
        out_ready   = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clear", 32'(out_valid), 0);
        check("idle_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_gcd_start", 32'(gcd_start), 0);
        check("rst_out_gcd", 32'(out_gcd), 0);
        check("rst_out_cycles", 32'(out_cycles), 0);
        check("rst_out_timeout", 32'(out_timeout), 0);
        check("rst_gcd_a", 32'(gcd_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // Normal pair, latency 5
        start_cycles = 0;
        send(8'd34, 8'd12, 5, 1'b1);
        recv(0, 1'b0);
        check("start_one_cycle", 32'(start_cycles), 1);
        check("start_gcd_a", 32'(start_a), 34);
        check("start_gcd_b", 32'(start_b), 12);

        // Zero operand: answered locally, responder untouched
        start_cycles = 0;
        send(8'd0, 8'd9, 5, 1'b1);
        check("zero_fast_valid", 32'(out_valid), 1);
        recv(0, 1'b0);
        check("zero_no_start", 32'(start_cycles), 0);

        // Hung responder -> timeout
        send(8'd21, 8'd14, 0, 1'b1);
        recv(0, 1'b0);

        // Recovery, then downstream stall with spurious finish pulses
        send(8'd15, 8'd10, 3, 1'b1);
        recv(10, 1'b1);

        // Finish on the first WAIT edge
        send(8'd48, 8'd18, 1, 1'b1);
        recv(0, 1'b0);

        // Reset asserted during WAIT
        start_cycles = 0;
        send(8'd40, 8'd16, 6, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_gcd_start", 32'(gcd_start), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_output", 32'(out_valid), 0);
        end
        check("midrst_single_start", 32'(start_cycles), 1);

`ifdef GCD_REQ_STATS_EN
        check("stat_min_rst", 32'(stat_min), 32'hFFFF);
        check("stat_max_rst", 32'(stat_max), 0);
        check("stat_count_rst", 32'(stat_count), 0);
`endif
        send(8'd34, 8'd12, 7, 1'b1);
        recv(0, 1'b0);
        send(8'd15, 8'd10, 3, 1'b1);
        recv(0, 1'b0);
        send(8'd99, 8'd33, 12, 1'b1);
        recv(0, 1'b0);
        send(8'd0, 8'd5, 4, 1'b1);
        recv(0, 1'b0);
        send(8'd5, 8'd7, 0, 1'b1);
        recv(0, 1'b0);
`ifdef GCD_REQ_STATS_EN
        check("stat_min", 32'(stat_min), 3);
        check("stat_max", 32'(stat_max), 12);
        check("stat_count", 32'(stat_count), 3);
`endif
        check("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
